// File: rtl/fpu_pkg.sv
// Shared definitions for the parametrised floating-point unit.
//   - operation codes (OP_ADD / OP_SUB / OP_MUL; code 2'b11 behaves as add)
//   - FSM state encoding
//   - bit positions inside the 4-bit flags vector
//   - helpers that derive the exponent bias and canonical quiet NaN from the
//     exponent/mantissa field widths (64-bit results, truncated by the caller)
package fpu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_EXEC,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    // flags = {invalid, overflow, underflow, inexact}
    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_INVALID   = 3;

    function automatic logic [63:0] fp_bias(input int exp_w);
        return (64'd1 << (exp_w - 1)) - 64'd1;
    endfunction

    // {sign 0, exponent all ones, fraction MSB set, rest zero}
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] exp_ones;
        exp_ones = (64'd1 << exp_w) - 64'd1;
        return (exp_ones << man_w) | (64'd1 << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter.
//   din   : N-bit vector, MSB first
//   count : number of zeros above the highest set bit (N when din is zero)
module fp_lzc #(
    parameter  int N  = 27,
    localparam int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  din,
    output logic [CW-1:0] count
);

    // Scanning upward lets the highest set bit overwrite any lower one.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        count = CW'(N);
        for (int i = 0; i < N; i++) begin
            if (din[i]) count = CW'(N - 1 - i);
        end
    end

endmodule

// File: rtl/fpu_param.sv
// Multi-cycle floating-point add / subtract / multiply unit with configurable
// exponent and fraction widths, round-to-nearest-even, no subnormals.
//   clk, rst     : rising-edge clock, asynchronous active-low reset
//   start, op    : request and operation, sampled only when idle
//   A, B         : operands, captured on the accepting edge
//   R, flags     : result and {invalid, overflow, underflow, inexact},
//                  held from done until the next accepted start
//   busy         : high while a transaction is in flight
//   done         : one-cycle pulse when R and flags are valid
module fpu_param
    import fpu_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = EXP_W + MAN_W + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] R,
    output logic         busy,
    output logic         done,
    output logic [3:0]   flags
);

    localparam int AW  = MAN_W + 4;          // {hidden, frac, G, R, S}
    localparam int SW  = MAN_W + 5;          // carry bit on top of AW
    localparam int N   = MAN_W + 1;          // multiplier operand width
    localparam int XW  = EXP_W + 2;          // signed working exponent
    localparam int LZW = $clog2(AW + 1);
    localparam int CW  = $clog2(N);

    localparam logic [W-1:0]          QNAN    = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic signed [XW-1:0]  BIAS    = XW'(fp_bias(EXP_W));
    localparam logic [EXP_W-1:0]      EXP_MAX = '1;
    localparam logic signed [XW-1:0]  EXP_INF = $signed({2'b00, EXP_MAX});
    localparam logic signed [XW-1:0]  ONE     = XW'(1);
    localparam logic signed [XW-1:0]  ZERO    = '0;

    state_t                state_q, state_d;
    logic [1:0]            op_q;
    logic [W-1:0]          a_q, b_q, res_q;
    logic [3:0]            res_flags_q;
    logic                  sign_q, eff_sub_q, zero_q;
    logic signed [XW-1:0]  exp_q;
    logic [SW-1:0]         sig_q;
    logic [AW-1:0]         big_q, small_q;
    logic [N-1:0]          mcand_q, mplier_q;
    logic [2*N-1:0]        prod_q;
    logic [CW-1:0]         cnt_q;

    // ---------------- unpack / classify ----------------
    logic             sa, sb, is_mul;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign is_mul = (op_q == OP_MUL);
    assign sa     = a_q[W-1];
    assign sb     = b_q[W-1] ^ (op_q == OP_SUB);
    assign ea     = a_q[W-2:MAN_W];
    assign eb     = b_q[W-2:MAN_W];
    assign fa     = a_q[MAN_W-1:0];
    assign fb     = b_q[MAN_W-1:0];
    // exp==0 flushes to zero, so any fraction there is ignored
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == EXP_MAX) && (fa == '0);
    assign b_inf  = (eb == EXP_MAX) && (fb == '0);
    assign a_nan  = (ea == EXP_MAX) && (fa != '0);
    assign b_nan  = (eb == EXP_MAX) && (fb != '0);

    logic         spec_hit;
    logic [W-1:0] spec_res;
    logic [3:0]   spec_flags;

    always_comb begin
        spec_hit   = 1'b1;
        spec_res   = '0;
        spec_flags = '0;
        if (a_nan || b_nan) begin
            spec_res                 = QNAN;
            spec_flags[FLAG_INVALID] = 1'b1;
        end else if (is_mul) begin
            if ((a_inf && b_zero) || (a_zero && b_inf)) begin
                spec_res                 = QNAN;
                spec_flags[FLAG_INVALID] = 1'b1;
            end else if (a_inf || b_inf) spec_res = {sa ^ sb, EXP_MAX, {MAN_W{1'b0}}};
            else if (a_zero || b_zero)   spec_res = {sa ^ sb, {(W-1){1'b0}}};
            else                         spec_hit = 1'b0;
        end else begin
            if (a_inf && b_inf && (sa != sb)) begin
                spec_res                 = QNAN;
                spec_flags[FLAG_INVALID] = 1'b1;
            end else if (a_inf)          spec_res = {sa, EXP_MAX, {MAN_W{1'b0}}};
            else if (b_inf)              spec_res = {sb, EXP_MAX, {MAN_W{1'b0}}};
            else if (a_zero && b_zero)   spec_res = {sa & sb, {(W-1){1'b0}}};
            else if (a_zero)             spec_res = {sb, eb, fb};
            else if (b_zero)             spec_res = {sa, ea, fa};
            else                         spec_hit = 1'b0;
        end
    end

    // ---------------- add-path alignment ----------------
    logic             sign_big;
    logic [EXP_W-1:0] e_big, e_small, diff;
    logic [AW-1:0]    sig_big, sig_small, small_mask, small_aligned;

    always_comb begin
        if ({ea, fa} >= {eb, fb}) begin
            sign_big  = sa;
            e_big     = ea;
            e_small   = eb;
            sig_big   = {1'b1, fa, 3'b000};
            sig_small = {1'b1, fb, 3'b000};
        end else begin
            sign_big  = sb;
            e_big     = eb;
            e_small   = ea;
            sig_big   = {1'b1, fb, 3'b000};
            sig_small = {1'b1, fa, 3'b000};
        end
        diff       = e_big - e_small;
        small_mask = ~({AW{1'b1}} << diff);
        if (int'(diff) >= AW) begin
            // the whole significand lands below S; only the sticky survives
            small_aligned = {{(AW-1){1'b0}}, 1'b1};
        end else begin
            small_aligned = (sig_small >> diff)
                          | {{(AW-1){1'b0}}, |(sig_small & small_mask)};
        end
    end

    logic signed [XW-1:0] mul_exp;
    assign mul_exp = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

    // ---------------- shift-add multiplier step ----------------
    logic [N:0]     mul_upper;
    logic [2*N-1:0] prod_next;
    logic [SW-1:0]  prod_sig;
    logic           mul_last;

    assign mul_upper = {1'b0, prod_q[2*N-1:N]} + (mplier_q[0] ? {1'b0, mcand_q} : {(N+1){1'b0}});
    assign prod_next = {mul_upper, prod_q[N-1:1]};
    // product MSB is the carry position; bits below R collapse into S
    assign prod_sig  = {prod_next[2*N-1:MAN_W-2], |prod_next[MAN_W-3:0]};
    assign mul_last  = (cnt_q == CW'(N - 1));

    // ---------------- normalise / round ----------------
    logic [LZW-1:0] lz;

    fp_lzc #(.N(AW)) u_lzc (
        .din   (sig_q[AW-1:0]),
        .count (lz)
    );

    logic                 rnd_inc;
    logic [MAN_W+1:0]     rnd_mant;
    logic signed [XW-1:0] rnd_exp;
    logic [W-1:0]         rnd_res;
    logic [3:0]           rnd_flags;

    always_comb begin
        rnd_inc  = sig_q[2] & (sig_q[1] | sig_q[0] | sig_q[3]);
        rnd_mant = {1'b0, sig_q[AW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_inc};
        rnd_exp  = exp_q;
        if (rnd_mant[MAN_W+1]) begin
            rnd_mant = rnd_mant >> 1;
            rnd_exp  = exp_q + ONE;
        end
        rnd_res                 = {sign_q, rnd_exp[EXP_W-1:0], rnd_mant[MAN_W-1:0]};
        rnd_flags               = '0;
        rnd_flags[FLAG_INEXACT] = |sig_q[2:0];
        if (zero_q) begin
            // exact cancellation always yields +0
            rnd_res   = '0;
            rnd_flags = '0;
        end else if (rnd_exp >= EXP_INF) begin
            rnd_res                   = {sign_q, EXP_MAX, {MAN_W{1'b0}}};
            rnd_flags[FLAG_OVERFLOW]  = 1'b1;
            rnd_flags[FLAG_INEXACT]   = 1'b1;
        end else if (rnd_exp <= ZERO) begin
            rnd_res                   = {sign_q, {(W-1){1'b0}}};
            rnd_flags[FLAG_UNDERFLOW] = 1'b1;
            rnd_flags[FLAG_INEXACT]   = 1'b1;
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_UNPACK;
            S_UNPACK: state_d = spec_hit ? S_DONE : S_EXEC;
            S_EXEC:   if (!is_mul || mul_last) state_d = S_NORM;
            S_NORM:   state_d = S_ROUND;
            S_ROUND:  state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ---------------- datapath and outputs ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            res_flags_q <= '0;
            sign_q      <= 1'b0;
            eff_sub_q   <= 1'b0;
            zero_q      <= 1'b0;
            exp_q       <= '0;
            sig_q       <= '0;
            big_q       <= '0;
            small_q     <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            R           <= '0;
            flags       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                S_IDLE: if (start) begin
                    a_q  <= A;
                    b_q  <= B;
                    op_q <= op;
                    busy <= 1'b1;
                end
                S_UNPACK: begin
                    res_q       <= spec_res;
                    res_flags_q <= spec_flags;
                    if (is_mul) begin
                        sign_q   <= sa ^ sb;
                        exp_q    <= mul_exp;
                        mcand_q  <= {1'b1, fa};
                        mplier_q <= {1'b1, fb};
                        prod_q   <= '0;
                        cnt_q    <= '0;
                    end else begin
                        sign_q    <= sign_big;
                        exp_q     <= $signed({2'b00, e_big});
                        big_q     <= sig_big;
                        small_q   <= small_aligned;
                        eff_sub_q <= sa ^ sb;
                    end
                end
                S_EXEC: begin
                    if (is_mul) begin
                        prod_q   <= prod_next;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + CW'(1);
                        if (mul_last) sig_q <= prod_sig;
                    end else if (eff_sub_q) begin
                        sig_q <= {1'b0, big_q} - {1'b0, small_q};
                    end else begin
                        sig_q <= {1'b0, big_q} + {1'b0, small_q};
                    end
                end
                S_NORM: begin
                    zero_q <= (sig_q == '0);
                    if (sig_q[SW-1]) begin
                        sig_q <= {1'b0, sig_q[SW-1:2], sig_q[1] | sig_q[0]};
                        exp_q <= exp_q + ONE;
                    end else begin
                        sig_q <= sig_q << lz;
                        exp_q <= exp_q - $signed({{(XW-LZW){1'b0}}, lz});
                    end
                end
                S_ROUND: begin
                    res_q       <= rnd_res;
                    res_flags_q <= rnd_flags;
                end
                S_DONE: begin
                    R     <= res_q;
                    flags <= res_flags_q;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_param.sv
// Directed self-checking bench for fpu_param: single precision instance plus
// a half-precision (EXP_W=5, MAN_W=10) instance sharing clock and reset.
module tb_fpu_param;
    import fpu_pkg::*;

    logic        clk;
    logic        rst;
    logic        start, start_h;
    logic [1:0]  op, op_h;
    logic [31:0] A, B, R;
    logic [15:0] a_h, b_h, r_h;
    logic        busy, done, busy_h, done_h;
    logic [3:0]  flags, flags_h;

    int checks = 0;
    int errors = 0;

    fpu_param dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .R     (R),
        .busy  (busy),
        .done  (done),
        .flags (flags)
    );

    fpu_param #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk   (clk),
        .rst   (rst),
        .start (start_h),
        .op    (op_h),
        .A     (a_h),
        .B     (b_h),
        .R     (r_h),
        .busy  (busy_h),
        .done  (done_h),
        .flags (flags_h)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction: latency is counted in rising edges from the accepting
    // edge to the edge after which done is seen high.
    task automatic run_op(input string tag, input bit half, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] exp_r,
                          input logic [3:0] exp_f, input bit poke);
        int cyc;
        bit seen;
        @(negedge clk);
        if (half) begin
            start_h = 1'b1; op_h = o; a_h = a[15:0]; b_h = b[15:0];
        end else begin
            start = 1'b1; op = o; A = a; B = b;
        end
        @(posedge clk); #1;
        start   = 1'b0;
        start_h = 1'b0;
        check({tag, " busy_after_start"}, 32'(half ? busy_h : busy), 32'd1);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            if (poke && cyc == 3) begin
                start = 1'b1; op = OP_ADD; A = 32'h3F800000; B = 32'h3F800000;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            seen = half ? done_h : done;
        end
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " R"}, half ? {16'h0, r_h} : R, exp_r);
        check({tag, " flags"}, 32'(half ? flags_h : flags), 32'(exp_f));
        check({tag, " busy_at_done"}, 32'(half ? busy_h : busy), 32'd0);
        @(posedge clk); #1;
        check({tag, " done_pulse"}, 32'(half ? done_h : done), 32'd0);
        check({tag, " R_held"}, half ? {16'h0, r_h} : R, exp_r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst = 1'b0; start = 1'b0; start_h = 1'b0;
        op = OP_ADD; op_h = OP_ADD; A = '0; B = '0; a_h = '0; b_h = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset R", R, 32'h0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset flags", 32'(flags), 32'd0);
        check("reset half R", {16'h0, r_h}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // 1.5 + 2.25 = 3.75
        run_op("add", 1'b0, OP_ADD, 32'h3FC00000, 32'h40100000, 5, 32'h40700000, 4'b0000, 1'b0);
        // 1.0 - 1.0 = +0
        run_op("sub_cancel", 1'b0, OP_SUB, 32'h3F800000, 32'h3F800000, 5, 32'h00000000, 4'b0000, 1'b0);
        // 1.0 + 2^-24 is an exact tie, rounds to even
        run_op("add_tie", 1'b0, OP_ADD, 32'h3F800000, 32'h33800000, 5, 32'h3F800000, 4'b0001, 1'b0);
        // 3.0 * 2.5 = 7.5, with a start pulse while busy
        run_op("mul", 1'b0, OP_MUL, 32'h40400000, 32'h40200000, 28, 32'h40F00000, 4'b0000, 1'b1);
        // inf * 0 -> qNaN, invalid
        run_op("mul_inf_zero", 1'b0, OP_MUL, 32'h7F800000, 32'h00000000, 2, 32'h7FC00000, 4'b1000, 1'b0);
        // inf + 1 -> inf
        run_op("add_inf", 1'b0, OP_ADD, 32'h7F800000, 32'h3F800000, 2, 32'h7F800000, 4'b0000, 1'b0);

        // reset during multiplier iteration aborts the transaction
        @(negedge clk);
        start = 1'b1; op = OP_MUL; A = 32'h40400000; B = 32'h40200000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort R", R, 32'h0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort flags", 32'(flags), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst  = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        check("abort no_done", 32'(seen), 32'd0);

        // max finite * 2 -> overflow
        run_op("mul_ovf", 1'b0, OP_MUL, 32'h7F7FFFFF, 32'h40000000, 28, 32'h7F800000, 4'b0101, 1'b0);
        // min normal squared -> underflow
        run_op("mul_unf", 1'b0, OP_MUL, 32'h00800000, 32'h00800000, 28, 32'h00000000, 4'b0011, 1'b0);
        // half precision 1.5 + 2.25 = 3.75
        run_op("half_add", 1'b1, OP_ADD, 32'h00003E00, 32'h00004080, 5, 32'h00004380, 4'b0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
